crc_tx_framer: RTL

- Transmit-side counterpart of the CRC checker path: accepts a stream of data words grouped into frames and computes a running CRC over each frame.
- After the last data word of a frame, appends one extra word carrying the CRC.
- Sits upstream of the link/memory whose far end compares a received CRC against a recomputed one.
- Uses a registered valid/ready stream on both sides with backpressure.

---
 rtl/crc_tx_framer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/crc_tx_framer.sv
// crc_tx_framer: passes framed data words through and appends one CRC word
// after the last data word of each frame. Valid/ready on both sides.
module crc_tx_framer #(
    parameter int unsigned                 DATA_WIDTH      = 8,
    parameter int unsigned                 POLYNOMIAL_BITS = 8,
    parameter logic [POLYNOMIAL_BITS-1:0]  POLYNOMIAL      = 8'h07,
    parameter logic [POLYNOMIAL_BITS-1:0]  CRC_INIT        = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_is_crc,
    output logic                  out_last,
    output logic [15:0]           frames_sent
);

    localparam int unsigned CW   = POLYNOMIAL_BITS;
    localparam int unsigned FS_W = 16;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_CRC  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         crc_q, crc_d;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  is_crc_d;
    logic                  last_d;
    logic                  free_c;

    // MSB-first, non-reflected CRC update over one whole word
    function automatic logic [CW-1:0] next_crc(input logic [CW-1:0] c,
                                               input logic [DATA_WIDTH-1:0] d);
        logic [CW-1:0] r;
        logic          fb;
        r = c;
        for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
            fb = r[CW-1] ^ d[i];
            r  = r << 1;
            if (fb) begin
                r = r ^ POLYNOMIAL;
            end
        end
        return r;
    endfunction

    // Output register can take a new word when empty or being drained
    assign free_c = !out_valid || out_ready;

    // State, CRC and output word registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_DATA;
            crc_q      <= CRC_INIT;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_is_crc <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            out_valid  <= valid_d;
            out_data   <= data_d;
            out_is_crc <= is_crc_d;
            out_last   <= last_d;
        end
    end

    // Next-state, next CRC and next output word
    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        valid_d  = out_valid;
        data_d   = out_data;
        is_crc_d = out_is_crc;
        last_d   = out_last;
        in_ready = 1'b0;
        case (state_q)
            ST_DATA: begin
                in_ready = free_c;
                if (in_valid && free_c) begin
                    valid_d  = 1'b1;
                    data_d   = in_data;
                    is_crc_d = 1'b0;
                    last_d   = 1'b0;
                    crc_d    = next_crc(crc_q, in_data);
                    if (in_last) begin
                        state_d = ST_CRC;
                    end
                end else if (free_c) begin
                    valid_d = 1'b0;
                end
            end
            ST_CRC: begin
                if (free_c) begin
                    valid_d  = 1'b1;
                    data_d   = DATA_WIDTH'(crc_q);
                    is_crc_d = 1'b1;
                    last_d   = 1'b1;
                    crc_d    = CRC_INIT;
                    state_d  = ST_DATA;
                end
            end
            default: begin
                state_d = ST_DATA;
            end
        endcase
    end

    // Completed-frame counter, bumped when a CRC word leaves
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames_sent <= '0;
        end else begin
            frames_sent <= frames_sent + FS_W'(out_valid && out_ready && out_is_crc);
        end
    end

endmodule
